// File: rtl/rv_core_pkg.sv
// Shared constants for the RV32 core support units: ALU op codes, forward
// selects and register address width, plus the forward-select helper.
package rv_core_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SLL    = 4'b0001;
    localparam logic [3:0] ALU_SLT    = 4'b0010;
    localparam logic [3:0] ALU_SLTU   = 4'b0011;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_SRL    = 4'b0101;
    localparam logic [3:0] ALU_OR     = 4'b0110;
    localparam logic [3:0] ALU_AND    = 4'b0111;
    localparam logic [3:0] ALU_MUL    = 4'b1000;
    localparam logic [3:0] ALU_MULH   = 4'b1001;
    localparam logic [3:0] ALU_MULHSU = 4'b1010;
    localparam logic [3:0] ALU_MULHU  = 4'b1011;
    localparam logic [3:0] ALU_DIV    = 4'b1100;
    localparam logic [3:0] ALU_DIVU   = 4'b1101;
    localparam logic [3:0] ALU_REM    = 4'b1110;
    localparam logic [3:0] ALU_REMU   = 4'b1111;

    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // The younger EX/MEM result takes priority over MEM/WB; x0 never forwards.
    function automatic logic [1:0] fwd_select(
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] ex_mem_rd,
        input logic                  ex_mem_we,
        input logic [REG_ADDR_W-1:0] mem_wb_rd,
        input logic                  mem_wb_we
    );
        logic [1:0] sel;
        if (ex_mem_we && (ex_mem_rd != 5'd0) && (ex_mem_rd == src)) begin
            sel = FWD_EXMEM;
        end else if (mem_wb_we && (mem_wb_rd != 5'd0) && (mem_wb_rd == src)) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_NONE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/rv_int_alu.sv
// Combinational RV32I ALU; the M-extension datapath is built only when the
// RV_MEXT_EN macro is defined, otherwise every op[3]=1 code returns zero.
import rv_core_pkg::*;

module rv_int_alu #(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        alu_op_i,
    input  logic [DATA_W-1:0] alu_a_i,
    input  logic [DATA_W-1:0] alu_b_i,
    output logic [DATA_W-1:0] alu_result_o
);

    logic [DATA_W-1:0] base_result_s;
    logic [DATA_W-1:0] mext_result_s;

    // Base integer operations selected by funct3.
    always_comb begin
        base_result_s = '0;
        case (alu_op_i[2:0])
            3'b000:  base_result_s = alu_a_i + alu_b_i;
            3'b001:  base_result_s = alu_a_i << alu_b_i[4:0];
            3'b010:  base_result_s = {{(DATA_W-1){1'b0}}, ($signed(alu_a_i) < $signed(alu_b_i))};
            3'b011:  base_result_s = {{(DATA_W-1){1'b0}}, (alu_a_i < alu_b_i)};
            3'b100:  base_result_s = alu_a_i ^ alu_b_i;
            3'b101:  base_result_s = alu_a_i >> alu_b_i[4:0];
            3'b110:  base_result_s = alu_a_i | alu_b_i;
            3'b111:  base_result_s = alu_a_i & alu_b_i;
            default: base_result_s = '0;
        endcase
    end

`ifdef RV_MEXT_EN
    logic                  mul_sign_a_s;
    logic                  mul_sign_b_s;
    logic [2*DATA_W-1:0]   prod_s;
    logic                  div_signed_s;
    logic                  a_neg_s;
    logic                  b_neg_s;
    logic                  b_zero_s;
    logic [DATA_W-1:0]     a_mag_s;
    logic [DATA_W-1:0]     b_mag_s;
    logic [DATA_W-1:0]     b_div_s;
    logic [DATA_W-1:0]     quot_mag_s;
    logic [DATA_W-1:0]     rem_mag_s;
    logic [DATA_W-1:0]     quot_s;
    logic [DATA_W-1:0]     rem_s;

    // One shared multiplier: operand extension picks signed/unsigned high half.
    always_comb begin
        mul_sign_a_s = alu_a_i[DATA_W-1] & ((alu_op_i[2:0] == 3'b001) | (alu_op_i[2:0] == 3'b010));
        mul_sign_b_s = alu_b_i[DATA_W-1] & (alu_op_i[2:0] == 3'b001);
        prod_s = {{DATA_W{mul_sign_a_s}}, alu_a_i} * {{DATA_W{mul_sign_b_s}}, alu_b_i};
    end

    // Sign-magnitude divider; 0x80000000/-1 falls out naturally as 0x80000000 rem 0.
    always_comb begin
        div_signed_s = ~alu_op_i[0];
        a_neg_s      = div_signed_s & alu_a_i[DATA_W-1];
        b_neg_s      = div_signed_s & alu_b_i[DATA_W-1];
        b_zero_s     = (alu_b_i == {DATA_W{1'b0}});
        a_mag_s      = a_neg_s ? (~alu_a_i + {{(DATA_W-1){1'b0}}, 1'b1}) : alu_a_i;
        b_mag_s      = b_neg_s ? (~alu_b_i + {{(DATA_W-1){1'b0}}, 1'b1}) : alu_b_i;
        b_div_s      = b_zero_s ? {{(DATA_W-1){1'b0}}, 1'b1} : b_mag_s;
        quot_mag_s   = a_mag_s / b_div_s;
        rem_mag_s    = a_mag_s % b_div_s;
        quot_s       = (a_neg_s ^ b_neg_s) ? (~quot_mag_s + {{(DATA_W-1){1'b0}}, 1'b1}) : quot_mag_s;
        rem_s        = a_neg_s ? (~rem_mag_s + {{(DATA_W-1){1'b0}}, 1'b1}) : rem_mag_s;
    end

    // M-extension result mux with divide-by-zero overrides.
    always_comb begin
        mext_result_s = '0;
        case (alu_op_i)
            ALU_MUL:    mext_result_s = prod_s[DATA_W-1:0];
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU:  mext_result_s = prod_s[2*DATA_W-1:DATA_W];
            ALU_DIV,
            ALU_DIVU:   mext_result_s = b_zero_s ? {DATA_W{1'b1}} : quot_s;
            ALU_REM,
            ALU_REMU:   mext_result_s = b_zero_s ? alu_a_i : rem_s;
            default:    mext_result_s = '0;
        endcase
    end
`else
    // No multiply/divide hardware in this build.
    always_comb begin
        mext_result_s = '0;
    end
`endif

    // Final selection between the base and M-extension results.
    always_comb begin
        if (alu_op_i[3]) begin
            alu_result_o = mext_result_s;
        end else begin
            alu_result_o = base_result_s;
        end
    end

endmodule

// File: rtl/rv_core_units.sv
// RV32 pipeline support block: 32x32 register file, ALU (M-ext when RV_MEXT_EN
// is defined) and load-use stall / forward-select logic.
import rv_core_pkg::*;

module rv_core_units #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0]     rs1_data,
    output logic [DATA_W-1:0]     rs2_data,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0]     rd_data,
    input  logic                  we,
    input  logic [3:0]            alu_op,
    input  logic [DATA_W-1:0]     alu_a,
    input  logic [DATA_W-1:0]     alu_b,
    output logic [DATA_W-1:0]     alu_result,
    input  logic                  id_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic [REG_ADDR_W-1:0] if_id_rs1,
    input  logic [REG_ADDR_W-1:0] if_id_rs2,
    input  logic [REG_ADDR_W-1:0] id_ex_rs1,
    input  logic [REG_ADDR_W-1:0] id_ex_rs2,
    input  logic [REG_ADDR_W-1:0] ex_mem_rd,
    input  logic [REG_ADDR_W-1:0] mem_wb_rd,
    input  logic                  ex_mem_reg_write,
    input  logic                  mem_wb_reg_write,
    output logic                  stall,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic [1:0]            forward_rs1_decode,
    output logic [1:0]            forward_rs2_decode
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    // Next register state: x0 is never written.
    always_comb begin
        regs_d = regs_q;
        if (we && (rd_addr != 5'd0)) begin
            regs_d[rd_addr] = rd_data;
        end else begin
            regs_d = regs_q;
        end
    end

    // Register state update; writes during reset are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Asynchronous reads with no write bypass; decode forwarding covers that case.
    always_comb begin
        if (rs1_addr == 5'd0) begin
            rs1_data = '0;
        end else begin
            rs1_data = regs_q[rs1_addr];
        end
        if (rs2_addr == 5'd0) begin
            rs2_data = '0;
        end else begin
            rs2_data = regs_q[rs2_addr];
        end
    end

    rv_int_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .alu_op_i    (alu_op),
        .alu_a_i     (alu_a),
        .alu_b_i     (alu_b),
        .alu_result_o(alu_result)
    );

    // Load-use stall and forward selects for EX and decode operands.
    always_comb begin
        stall = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));
        forward_a          = fwd_select(id_ex_rs1, ex_mem_rd, ex_mem_reg_write, mem_wb_rd, mem_wb_reg_write);
        forward_b          = fwd_select(id_ex_rs2, ex_mem_rd, ex_mem_reg_write, mem_wb_rd, mem_wb_reg_write);
        forward_rs1_decode = fwd_select(if_id_rs1, ex_mem_rd, ex_mem_reg_write, mem_wb_rd, mem_wb_reg_write);
        forward_rs2_decode = fwd_select(if_id_rs2, ex_mem_rd, ex_mem_reg_write, mem_wb_rd, mem_wb_reg_write);
    end

endmodule

// File: tb/tb_rv_core_units.sv
// Self-checking bench for rv_core_units: a behavioural model checked every
// cycle, plus directed vectors with literal expectations.
module tb_rv_core_units;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [31:0] rs1_data, rs2_data, rd_data;
    logic        we;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_rd, if_id_rs1, if_id_rs2, id_ex_rs1, id_ex_rs2, ex_mem_rd, mem_wb_rd;
    logic        ex_mem_reg_write, mem_wb_reg_write;
    logic        stall;
    logic [1:0]  forward_a, forward_b, forward_rs1_decode, forward_rs2_decode;

`ifdef RV_MEXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    rv_core_units dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .we(we),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2),
        .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
        .ex_mem_reg_write(ex_mem_reg_write), .mem_wb_reg_write(mem_wb_reg_write),
        .stall(stall), .forward_a(forward_a), .forward_b(forward_b),
        .forward_rs1_decode(forward_rs1_decode), .forward_rs2_decode(forward_rs2_decode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mregs [32];
    bit          model_ok = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mregs[i] <= 32'd0;
            model_ok <= 1'b1;
        end else if (we && rd_addr != 5'd0) begin
            mregs[rd_addr] <= rd_data;
        end
    end

    function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        longint r;
        if (op[3] && !MEXT) return 32'd0;
        case (op)
            4'd0:  r = ua + ub;
            4'd1:  r = ua << b[4:0];
            4'd2:  r = (sa < sb) ? 64'd1 : 64'd0;
            4'd3:  r = (ua < ub) ? 64'd1 : 64'd0;
            4'd4:  r = ua ^ ub;
            4'd5:  r = ua >> b[4:0];
            4'd6:  r = ua | ub;
            4'd7:  r = ua & ub;
            4'd8:  r = ua * ub;
            4'd9:  r = (sa * sb) >>> 32;
            4'd10: r = (sa * ub) >>> 32;
            4'd11: r = (ua * ub) >>> 32;
            4'd12: r = (b == 32'd0) ? -64'sd1 : sa / sb;
            4'd13: r = (b == 32'd0) ? -64'sd1 : ua / ub;
            4'd14: r = (b == 32'd0) ? sa : sa % sb;
            default: r = (b == 32'd0) ? ua : ua % ub;
        endcase
        return r[31:0];
    endfunction

    function automatic logic [1:0] model_fwd(input logic [4:0] s);
        if (ex_mem_reg_write && ex_mem_rd != 5'd0 && ex_mem_rd == s) return 2'd1;
        if (mem_wb_reg_write && mem_wb_rd != 5'd0 && mem_wb_rd == s) return 2'd2;
        return 2'd0;
    endfunction

    // Compare process: every cycle once the model has seen reset.
    always @(negedge clk) begin
        if (model_ok) begin
            check("m_rs1", rs1_data, mregs[rs1_addr]);
            check("m_rs2", rs2_data, mregs[rs2_addr]);
        end
        check("m_alu", alu_result, model_alu(alu_op, alu_a, alu_b));
        check("m_stall", {31'd0, stall},
              {31'd0, id_ex_mem_read && id_ex_rd != 5'd0 && (id_ex_rd == if_id_rs1 || id_ex_rd == if_id_rs2)});
        check("m_fwd_a", {30'd0, forward_a}, {30'd0, model_fwd(id_ex_rs1)});
        check("m_fwd_b", {30'd0, forward_b}, {30'd0, model_fwd(id_ex_rs2)});
        check("m_fwd_d1", {30'd0, forward_rs1_decode}, {30'd0, model_fwd(if_id_rs1)});
        check("m_fwd_d2", {30'd0, forward_rs2_decode}, {30'd0, model_fwd(if_id_rs2)});
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_m;
    } alu_vec_t;

    alu_vec_t vecs[$];

    initial begin
        rst = 1'b1; we = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEAD;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        alu_op = 4'd0; alu_a = 32'd0; alu_b = 32'd0;
        id_ex_mem_read = 1'b0; id_ex_rd = 5'd0; if_id_rs1 = 5'd0; if_id_rs2 = 5'd0;
        id_ex_rs1 = 5'd0; id_ex_rs2 = 5'd0; ex_mem_rd = 5'd0; mem_wb_rd = 5'd0;
        ex_mem_reg_write = 1'b0; mem_wb_reg_write = 1'b0;
        step(); step();
        rst = 1'b0; we = 1'b0; rs1_addr = 5'd5;
        @(negedge clk);
        check("reset_x5", rs1_data, 32'd0);

        // Register file writes, x0 protection, no bypass
        step(); we = 1'b1; rd_addr = 5'd5; rd_data = 32'h1234;
        step(); rd_addr = 5'd0; rd_data = 32'hFFFF;
        step(); we = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd0;
        @(negedge clk);
        check("read_x5", rs1_data, 32'h1234);
        check("read_x0", rs2_data, 32'd0);
        step(); we = 1'b1; rd_addr = 5'd5; rd_data = 32'h9;
        @(negedge clk);
        check("no_bypass", rs1_data, 32'h1234);
        step(); we = 1'b0;
        @(negedge clk);
        check("write_x5_9", rs1_data, 32'h9);
        step(); we = 1'b1; rd_addr = 5'd31; rd_data = 32'hCAFE_F00D; rs2_addr = 5'd31;
        step(); we = 1'b0;
        @(negedge clk);
        check("read_x31", rs2_data, 32'hCAFE_F00D);

        // ALU vectors; exp_m is the M-ext-enabled answer, base ops are unaffected
        vecs.push_back('{4'd0,  32'hFFFFFFFF, 32'd1,        32'd0});
        vecs.push_back('{4'd0,  32'h7FFFFFFF, 32'd1,        32'h80000000});
        vecs.push_back('{4'd2,  32'hFFFFFFFF, 32'd1,        32'd1});
        vecs.push_back('{4'd2,  32'd1,        32'hFFFFFFFF, 32'd0});
        vecs.push_back('{4'd3,  32'hFFFFFFFF, 32'd1,        32'd0});
        vecs.push_back('{4'd5,  32'h80000000, 32'd31,       32'd1});
        vecs.push_back('{4'd5,  32'hF0000000, 32'd4,        32'h0F000000});
        vecs.push_back('{4'd1,  32'd1,        32'd36,       32'h10});
        vecs.push_back('{4'd4,  32'h0000F0F0, 32'h00000FF0, 32'h0000FF00});
        vecs.push_back('{4'd6,  32'hF0000000, 32'd1,        32'hF0000001});
        vecs.push_back('{4'd7,  32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00});
        vecs.push_back('{4'd8,  32'd3,        32'd4,        32'd12});
        vecs.push_back('{4'd8,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1});
        vecs.push_back('{4'd9,  32'h80000000, 32'h80000000, 32'h40000000});
        vecs.push_back('{4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF});
        vecs.push_back('{4'd11, 32'hFFFFFFFF, 32'd2,        32'd1});
        vecs.push_back('{4'd12, 32'd7,        32'd0,        32'hFFFFFFFF});
        vecs.push_back('{4'd12, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD});
        vecs.push_back('{4'd12, 32'h80000000, 32'hFFFFFFFF, 32'h80000000});
        vecs.push_back('{4'd13, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF});
        vecs.push_back('{4'd13, 32'd7,        32'd0,        32'hFFFFFFFF});
        vecs.push_back('{4'd14, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF});
        vecs.push_back('{4'd14, 32'h80000000, 32'hFFFFFFFF, 32'd0});
        vecs.push_back('{4'd14, 32'd5,        32'd0,        32'd5});
        vecs.push_back('{4'd15, 32'd7,        32'd3,        32'd1});
        vecs.push_back('{4'd15, 32'd7,        32'd0,        32'd7});
        foreach (vecs[i]) begin
            step();
            alu_op = vecs[i].op; alu_a = vecs[i].a; alu_b = vecs[i].b;
            @(negedge clk);
            check($sformatf("alu_vec%0d_op%0d", i, vecs[i].op), alu_result,
                  (vecs[i].op[3] && !MEXT) ? 32'd0 : vecs[i].exp_m);
        end

        // Load-use stall
        step(); id_ex_mem_read = 1'b1; id_ex_rd = 5'd3; if_id_rs1 = 5'd1; if_id_rs2 = 5'd3;
        @(negedge clk);
        check("stall_rs2", {31'd0, stall}, 32'd1);
        step(); id_ex_rd = 5'd0; if_id_rs2 = 5'd0;
        @(negedge clk);
        check("stall_x0", {31'd0, stall}, 32'd0);
        step(); id_ex_rd = 5'd3; if_id_rs2 = 5'd3; id_ex_mem_read = 1'b0;
        @(negedge clk);
        check("stall_noload", {31'd0, stall}, 32'd0);
        id_ex_mem_read = 1'b0; if_id_rs1 = 5'd0; if_id_rs2 = 5'd0;

        // Forwarding priority
        step(); ex_mem_rd = 5'd7; mem_wb_rd = 5'd7; id_ex_rs1 = 5'd7;
        ex_mem_reg_write = 1'b1; mem_wb_reg_write = 1'b1;
        @(negedge clk);
        check("fwd_a_exmem", {30'd0, forward_a}, 32'd1);
        step(); ex_mem_reg_write = 1'b0;
        @(negedge clk);
        check("fwd_a_memwb", {30'd0, forward_a}, 32'd2);
        step(); ex_mem_rd = 5'd0; mem_wb_rd = 5'd0; id_ex_rs1 = 5'd0; ex_mem_reg_write = 1'b1;
        @(negedge clk);
        check("fwd_a_x0", {30'd0, forward_a}, 32'd0);
        step(); ex_mem_rd = 5'd9; id_ex_rs2 = 5'd9;
        @(negedge clk);
        check("fwd_b_exmem", {30'd0, forward_b}, 32'd1);

        // Decode forwarding
        step(); ex_mem_reg_write = 1'b0; mem_wb_rd = 5'd4; if_id_rs1 = 5'd4; if_id_rs2 = 5'd6;
        mem_wb_reg_write = 1'b1;
        @(negedge clk);
        check("fwd_d1_memwb", {30'd0, forward_rs1_decode}, 32'd2);
        check("fwd_d2_none", {30'd0, forward_rs2_decode}, 32'd0);

        step();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_core_units.md
Name: rv_core_units

Overview:
- Combined support block for the 5-stage RV32 pipeline: 32x32 register file, integer ALU (RV32I ops plus M-extension), and load-use hazard / forwarding-select unit.
- The pipeline top instantiates it once.
- Register file is the only state; the ALU and hazard logic are purely combinational.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- NREG, 32, number of architectural registers; register address is 5 bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rs1_addr  in  5  read port A address (decode stage).
- rs2_addr  in  5  read port B address.
- rs1_data  out  32  register[rs1_addr], combinational.
- rs2_data  out  32  register[rs2_addr], combinational.
- rd_addr  in  5  write address (writeback stage).
- rd_data  in  32  write data.
- we  in  1  write enable.
- alu_op  in  4  ALU operation; bit3 = M-extension, bits2:0 = funct3.
- alu_a  in  32  ALU operand A.
- alu_b  in  32  ALU operand B.
- alu_result  out  32  ALU result, combinational.
- id_ex_mem_read  in  1  instruction in EX is a load.
- id_ex_rd  in  5  destination register of the EX instruction.
- if_id_rs1, if_id_rs2  in  5 each  source registers of the decode instruction.
- id_ex_rs1, id_ex_rs2  in  5 each  source registers of the EX instruction.
- ex_mem_rd, mem_wb_rd  in  5 each  destination registers in MEM and WB.
- ex_mem_reg_write, mem_wb_reg_write  in  1 each  write-enables in MEM and WB.
- stall  out  1  load-use stall request.
- forward_a, forward_b  out  2 each  EX operand forward selects.
- forward_rs1_decode, forward_rs2_decode  out  2 each  decode operand forward selects.

Behaviour:
- Register file
  - Reset: all 32 registers become 0 on the first rising edge with rst=1. Writes presented while rst=1 are discarded.
  - Write: on a rising edge with we=1 and rd_addr!=0, register[rd_addr] <= rd_data. Writes to x0 are ignored.
  - Read: reads are asynchronous. x0 always reads 0.
  - No internal write-to-read bypass: a same-cycle read of the register being written returns the old value (the pipeline covers this case with decode forwarding).
- ALU (op[3]=0)
  - 000 ADD; 001 SLL by b[4:0]; 010 SLT (signed, result 1/0); 011 SLTU; 100 XOR; 101 SRL logical by b[4:0]; 110 OR; 111 AND.
  - Add wraps modulo 2^32.
- ALU (op[3]=1)
  - 000 MUL: low 32 bits of the product.
  - 001 MULH (signed x signed), 010 MULHSU (signed x unsigned), 011 MULHU (unsigned x unsigned): high 32 bits of the product.
  - 100 DIV, 101 DIVU: quotient rounds toward zero.
  - 110 REM, 111 REMU: remainder takes the sign of the dividend.
  - Divide by zero: DIV/DIVU = 0xFFFFFFFF; REM/REMU = a.
  - Signed overflow (0x80000000 / -1): DIV = 0x80000000, REM = 0.
- Hazard unit
  - stall = id_ex_mem_read & (id_ex_rd!=0) & (id_ex_rd==if_id_rs1 | id_ex_rd==if_id_rs2).
  - Forward select encoding: 00 = no forward, 01 = EX/MEM result, 10 = MEM/WB result. Encoding 11 is never produced.
  - For each select with source register s (forward_a: s=id_ex_rs1; forward_b: s=id_ex_rs2; forward_rs1_decode: s=if_id_rs1; forward_rs2_decode: s=if_id_rs2):
    - 01 if ex_mem_reg_write & ex_mem_rd!=0 & ex_mem_rd==s;
    - else 10 if mem_wb_reg_write & mem_wb_rd!=0 & mem_wb_rd==s;
    - else 00.
  - When both stages match, EX/MEM wins.
- All combinational outputs are valid in the same cycle as their inputs and are independent of rst.

Optional Feature:
- Macro RV_MEXT_EN.
- Defined: the eight op[3]=1 operations are implemented as specified above.
- Not defined: no multiply/divide hardware is built, and every op[3]=1 encoding returns 0x00000000.
- The register file and hazard unit are unaffected either way.

Decomposition:
- Package rv_core_pkg holds:
  - ALU op constants (ALU_ADD..ALU_AND, ALU_MUL..ALU_REMU);
  - forward-select constants FWD_NONE=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10;
  - REG_ADDR_W=5.
- One natural sub-module: rv_int_alu, the combinational ALU including the RV_MEXT_EN logic. Register file and hazard logic stay inline.

Test Plan:
- Reset, then write x5=0x1234 and x0=0xFFFF with we=1 -> rs1_addr=5 reads 0x1234; rs2_addr=0 reads 0; a same-cycle read of x5 while writing 0x9 returns 0x1234, and 0x9 the next cycle.
- ALU: ADD 0xFFFFFFFF+1 -> 0; SLT 0xFFFFFFFF,1 -> 1; SLTU same operands -> 0; SRL 0x80000000 by 31 -> 1; SLL 1 by 36 -> 0x10.
- M ops (RV_MEXT_EN defined): MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*2 -> 1; DIV 7/0 -> 0xFFFFFFFF; REM -7/2 -> 0xFFFFFFFF; DIV 0x80000000/-1 -> 0x80000000. Without the macro, MUL 3*4 -> 0.
- Load-use: id_ex_mem_read=1, id_ex_rd=3, if_id_rs2=3 -> stall=1; the same with id_ex_rd=0 -> stall=0.
- Forwarding priority: ex_mem_rd=mem_wb_rd=id_ex_rs1=7, both write-enables=1 -> forward_a=01; clear ex_mem_reg_write -> forward_a=10; set rd=0 -> 00.
- Decode forwarding: mem_wb_rd=if_id_rs1=4, mem_wb_reg_write=1 -> forward_rs1_decode=10; forward_rs2_decode=00.
